// File: rtl/arith_ctrl_pkg.sv
// Shared types and constants for the arithmetic-engine control blocks.
package arith_ctrl_pkg;

  // Scheduler FSM: grant in idle, pulse the engine, wait for it, hand back the result.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StRun   = 2'd2,
    StResp  = 2'd3
  } sched_state_e;

  // Slack added on top of the engine's nominal latency before it is declared hung.
  localparam int unsigned TimeoutMargin = 4;

endpackage

// File: rtl/dot_product_scheduler_if.sv
// Requester handshakes, response bus and engine control of the dot-product scheduler.
// master: the scheduler itself; slave: the requesters plus the engine.
interface dot_product_scheduler_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = 31
);
  localparam int unsigned SelW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [WORD_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  eng_start;
  logic [SelW-1:0]       eng_sel;
  logic                  eng_valid;
  logic [WORD_WIDTH-1:0] eng_result;

  modport master (
    input  req_valid, resp_ready, eng_valid, eng_result,
    output req_ready, resp_valid, resp_data, resp_err, eng_start, eng_sel
  );

  modport slave (
    output req_valid, resp_ready, eng_valid, eng_result,
    input  req_ready, resp_valid, resp_data, resp_err, eng_start, eng_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IdxW-1:0]    idx
);

  logic            found;
  logic [IdxW-1:0] cand;

  // Scan from the pointer upward; NUM_REQ is a power of two so the index wraps for free.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IdxW'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Shares one M31 dot-product engine among NUM_REQ requesters, one job at a time,
// with round-robin grants and a hung-engine timeout.
module dot_product_scheduler
  import arith_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WORD_WIDTH  = 31,
  parameter int unsigned VECTOR_SIZE = 16,
  parameter int unsigned TIMEOUT     = VECTOR_SIZE + TimeoutMargin
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dot_product_scheduler_if.master  bus,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned SelW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  sched_state_e          state_q, state_d;
  logic [SelW-1:0]       ptr_q, ptr_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [SelW-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [WORD_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic                  eng_start;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (SelW)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Next-state and output decode; every path starts from hold/zero defaults.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    eng_start  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          req_ready = gnt;
          sel_d     = gnt_idx;
          state_d   = StStart;
        end
      end
      StStart: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = StRun;
      end
      StRun: begin
        // A result in the last allowed cycle still wins over the timeout.
        if (bus.eng_valid) begin
          data_d  = bus.eng_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          data_d    = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        resp_valid[sel_q] = 1'b1;
        resp_data         = data_q;
        resp_err          = err_q;
        if (bus.resp_ready[sel_q]) begin
          ptr_d   = sel_q + SelW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any job in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  // The grant is combinational from req_valid, so mask it while reset is held.
  assign bus.req_ready  = reset_n ? req_ready : '0;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_err   = resp_err;
  assign bus.eng_start  = eng_start;
  assign bus.eng_sel    = sel_q;
  assign busy           = (state_q != StIdle);
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Self-checking bench for dot_product_scheduler with a scoreboard of expected responses.
module tb_dot_product_scheduler;

  localparam int TIMEOUT = 20;

  typedef struct {
    int          idx;
    logic [30:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic reset_n;
  logic busy;
  logic timeout_err;

  dot_product_scheduler_if #(.NUM_REQ(4), .WORD_WIDTH(31)) bus ();

  dot_product_scheduler #(
    .NUM_REQ     (4),
    .WORD_WIDTH  (31),
    .VECTOR_SIZE (16),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ptr_m    = 0;
  logic to_m     = 1'b0;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    onehot = 4'b0001 << i;
  endfunction

  function automatic int rr_model(input logic [3:0] m);
    int k;
    rr_model = -1;
    for (int i = 3; i >= 0; i--) begin
      k = (ptr_m + i) % 4;
      if (m[k]) rr_model = k;
    end
  endfunction

  function automatic logic [63:0] all_outs();
    all_outs = 64'({bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_err,
                    bus.eng_start, bus.eng_sel, busy, timeout_err});
  endfunction

  // lat = 0 models a hung engine; keep holds req_valid; stray pulses eng_valid in START.
  task automatic run_job(input logic [3:0] mask, input int lat, input logic [30:0] data,
                         input int bp, input bit keep, input bit stray);
    int   exp_idx;
    int   c;
    bit   got;
    exp_t e;
    exp_idx = rr_model(mask);
    bus.req_valid = mask;
    #1;
    check_eq("grant", bus.req_ready, onehot(exp_idx));
    check_eq("idle_busy", busy, 0);
    sb.push_back('{idx: exp_idx, data: (lat == 0) ? 31'd0 : data, err: (lat == 0)});
    @(posedge clk); #1;
    if (!keep) bus.req_valid = '0;
    if (stray) begin
      bus.eng_valid  = 1'b1;
      bus.eng_result = 31'h7fff_0bad;
    end
    #1;
    check_eq("start_pulse", bus.eng_start, 1);
    check_eq("start_sel", bus.eng_sel, exp_idx);
    check_eq("start_ready", bus.req_ready, 0);
    c   = 1;
    got = 1'b0;
    while (!got && c < 60) begin
      @(posedge clk); #1;
      c++;
      bus.eng_valid  = (lat != 0 && c == lat + 1);
      bus.eng_result = bus.eng_valid ? data : 31'd0;
      if (bus.resp_valid != 0) got = 1'b1;
    end
    bus.eng_valid  = 1'b0;
    bus.eng_result = '0;
    if (!got) begin
      check_eq("resp_wait", 0, 1);
      return;
    end
    e = sb.pop_front();
    if (e.err) to_m = 1'b1;
    check_eq("latency", c, (lat == 0) ? TIMEOUT + 2 : lat + 2);
    check_eq("resp_valid", bus.resp_valid, onehot(e.idx));
    check_eq("resp_data", bus.resp_data, e.data);
    check_eq("resp_err", bus.resp_err, e.err);
    check_eq("timeout_err", timeout_err, to_m);
    check_eq("resp_sel", bus.eng_sel, e.idx);
    for (int i = 0; i < bp; i++) begin
      bus.resp_ready = ~onehot(e.idx);
      @(posedge clk); #1;
      check_eq("bp_valid", bus.resp_valid, onehot(e.idx));
      check_eq("bp_data", bus.resp_data, e.data);
      check_eq("bp_ready", bus.req_ready, 0);
    end
    bus.resp_ready = onehot(e.idx);
    @(posedge clk); #1;
    bus.resp_ready = '0;
    check_eq("done_valid", bus.resp_valid, 0);
    check_eq("done_busy", busy, 0);
    ptr_m = (e.idx + 1) % 4;
  endtask

  int lats[8] = '{1, 19, 5, 16, 2, 8, 3, 12};
  bit seen;
  int exp_idx;

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.eng_valid  = 1'b0;
    bus.eng_result = '0;
    #1;
    check_eq("reset_outs", all_outs(), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Fairness: all four requesting for eight jobs.
    for (int j = 0; j < 8; j++) begin
      check_eq("rr_order", rr_model(4'hf), j % 4);
      run_job(4'hf, lats[j], 31'($urandom), 0, 1'b1, 1'b0);
    end

    // Single request, 16-cycle engine, stray eng_valid during START.
    run_job(4'b0001, 16, 31'h1234, 0, 1'b0, 1'b1);

    // Stray eng_valid in IDLE.
    for (int i = 0; i < 3; i++) begin
      bus.eng_valid  = 1'b1;
      bus.eng_result = 31'h5a5a;
      @(posedge clk); #1;
      check_eq("stray_idle", {busy, bus.resp_valid, bus.eng_start}, 0);
    end
    bus.eng_valid = 1'b0;

    run_job(4'b0010, 5, 31'h2abc_def0, 10, 1'b1, 1'b0);  // backpressure
    run_job(4'b0100, 0, 31'h0, 0, 1'b0, 1'b0);           // hung engine
    run_job(4'b1000, 7, 31'h0765_4321, 0, 1'b0, 1'b0);   // timeout_err stays set
    run_job(4'b0001, 2, 31'h0000_0042, 0, 1'b0, 1'b0);

    // Reset in the middle of RUN.
    bus.req_valid = 4'hf;
    #1;
    exp_idx = rr_model(4'hf);
    check_eq("rst_grant", bus.req_ready, onehot(exp_idx));
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (6) @(posedge clk);
    #1;
    bus.req_valid = 4'hf;
    reset_n       = 1'b0;
    #1;
    check_eq("rst_async", all_outs(), 0);
    @(posedge clk); #1;
    check_eq("rst_hold", all_outs(), 0);
    reset_n       = 1'b1;
    bus.req_valid = '0;
    ptr_m         = 0;
    to_m          = 1'b0;
    seen          = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      bus.eng_valid  = (i == 10);
      bus.eng_result = 31'h1111;
      if (bus.resp_valid != 0 || busy) seen = 1'b1;
    end
    bus.eng_valid = 1'b0;
    check_eq("rst_no_resp", seen, 0);
    run_job(4'hf, 16, 31'h3333_cccc, 0, 1'b0, 1'b0);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
